// File: rtl/arcade_input.sv
// Arcade control merger: PS/2 key latches and hps_io joystick words combine into per-player
// control words, with coin pulse shaping, a global pause toggle and button-0 autofire.
module arcade_input #(
  parameter int unsigned PLAYERS      = 2,
  parameter int unsigned BUTTONS      = 3,
  parameter int unsigned COIN_PULSE   = 16,
  parameter int unsigned AUTOFIRE_DIV = 8
) (
  input  logic                           clk_sys_i,
  input  logic                           reset_n_i,
  input  logic [10:0]                    ps2_key_i,
  input  logic [16*PLAYERS-1:0]          joystick_i,
  input  logic [PLAYERS-1:0]             autofire_en_i,
  input  logic                           clear_i,
  output logic [(6+BUTTONS)*PLAYERS-1:0] player_o,
  output logic                           pause_o,
  output logic [1:0]                     service_o
);

  localparam int unsigned OutW     = 6 + BUTTONS;
  localparam int unsigned RawW     = 7 + BUTTONS;
  localparam int unsigned StartBit = 4 + BUTTONS;
  localparam int unsigned CoinBit  = 5 + BUTTONS;
  localparam int unsigned PauseBit = 6 + BUTTONS;
  localparam int unsigned CoinW    = $clog2(COIN_PULSE + 1);
  localparam int unsigned AfW      = $clog2(AUTOFIRE_DIV + 1);

  localparam logic [CoinW-1:0] CoinLoad = CoinW'(COIN_PULSE - 1);
  localparam logic [AfW-1:0]   AfLast   = AfW'(AUTOFIRE_DIV - 1);

  logic                 strobe_q;
  logic                 key_evt;
  logic                 key_prs;
  logic [1:0][RawW-1:0] key_q, key_d;
  logic [1:0]           svc_q, svc_d;
  logic [1:0]           service_q;
  logic                 pause_q, pause_d;
  logic [PLAYERS-1:0]   pause_rise;
  logic                 unused_ext;

  assign key_evt    = ps2_key_i[10] ^ strobe_q;
  assign key_prs    = ps2_key_i[9];
  assign unused_ext = ps2_key_i[8];

  // Keyboard latches: only players 1 and 2 have key maps; extended prefix is ignored.
  always_comb begin
    key_d = key_q;
    svc_d = svc_q;
    if (clear_i) begin
      key_d = '0;
      svc_d = '0;
    end else if (key_evt) begin
      case (ps2_key_i[7:0])
        8'h75: key_d[0][3]        = key_prs;
        8'h72: key_d[0][2]        = key_prs;
        8'h6b: key_d[0][1]        = key_prs;
        8'h74: key_d[0][0]        = key_prs;
        8'h14: key_d[0][4]        = key_prs;
        8'h11: if (BUTTONS > 1) key_d[0][5] = key_prs;
        8'h29: if (BUTTONS > 2) key_d[0][6] = key_prs;
        8'h16: key_d[0][StartBit] = key_prs;
        8'h2e: key_d[0][CoinBit]  = key_prs;
        8'h4d: key_d[0][PauseBit] = key_prs;
        8'h2d: if (PLAYERS > 1) key_d[1][3] = key_prs;
        8'h2b: if (PLAYERS > 1) key_d[1][2] = key_prs;
        8'h23: if (PLAYERS > 1) key_d[1][1] = key_prs;
        8'h34: if (PLAYERS > 1) key_d[1][0] = key_prs;
        8'h1c: if (PLAYERS > 1) key_d[1][4] = key_prs;
        8'h1b: if (PLAYERS > 1 && BUTTONS > 1) key_d[1][5] = key_prs;
        8'h15: if (PLAYERS > 1 && BUTTONS > 2) key_d[1][6] = key_prs;
        8'h1e: if (PLAYERS > 1) key_d[1][StartBit] = key_prs;
        8'h36: if (PLAYERS > 1) key_d[1][CoinBit]  = key_prs;
        8'h46: svc_d[0] = key_prs;
        8'h45: svc_d[1] = key_prs;
        default: ;
      endcase
    end
  end

  // Several players pressing pause in the same cycle still toggle only once.
  assign pause_d = clear_i ? 1'b0 : (pause_q ^ (|pause_rise));

  always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      strobe_q  <= 1'b0;
      key_q     <= '0;
      svc_q     <= '0;
      service_q <= '0;
      pause_q   <= 1'b0;
    end else begin
      strobe_q  <= ps2_key_i[10];
      key_q     <= key_d;
      svc_q     <= svc_d;
      service_q <= svc_q;
      pause_q   <= pause_d;
    end
  end

  assign pause_o   = pause_q;
  assign service_o = service_q;

  for (genvar g = 0; g < PLAYERS; g++) begin : g_player
    logic [RawW-1:0]   key;
    logic [RawW-1:0]   raw;
    logic [OutW-1:0]   player_q, player_d;
    logic [CoinW-1:0]  coin_cnt_q, coin_cnt_d;
    logic              coin_low_q, coin_low_d;
    logic              coin_rise;
    logic              pause_low_q, pause_low_d;
    logic              rise_l;
    logic [AfW-1:0]    af_cnt_q, af_cnt_d;
    logic              af_ph_q, af_ph_d;
    logic              af_arm_q, af_arm_d;
    logic              btn0;
    logic [15-RawW:0]  unused_hi;

    if (g < 2) begin : g_key
      assign key = key_q[g];
    end else begin : g_no_key
      assign key = '0;
    end

    assign unused_hi = joystick_i[16*g+RawW +: 16-RawW];
    // Latches are masked during clear so the cleared state shows on the very next edge.
    assign raw = joystick_i[16*g +: RawW] | (clear_i ? '0 : key);

    always_comb begin
      // *_low_q remembers the input was seen low; reset/clear leave it 0 so a held
      // input cannot fire until it has been released.
      coin_rise  = raw[CoinBit] & coin_low_q & (coin_cnt_q == '0) & ~clear_i;
      coin_low_d = ~raw[CoinBit] & ~clear_i;
      if (clear_i) begin
        coin_cnt_d = '0;
      end else if (coin_rise) begin
        coin_cnt_d = CoinLoad;
      end else if (coin_cnt_q != '0) begin
        coin_cnt_d = coin_cnt_q - CoinW'(1);
      end else begin
        coin_cnt_d = '0;
      end

      rise_l      = raw[PauseBit] & pause_low_q & ~clear_i;
      pause_low_d = ~raw[PauseBit] & ~clear_i;

      af_cnt_d = '0;
      af_ph_d  = 1'b0;
      af_arm_d = af_arm_q | ~raw[4];
      btn0     = raw[4];
      if (autofire_en_i[g] && !clear_i) begin
        btn0 = 1'b0;
        if (raw[4] && af_arm_q) begin
          btn0 = ~af_ph_q;
          if (af_cnt_q == AfLast) begin
            af_ph_d = ~af_ph_q;
          end else begin
            af_cnt_d = af_cnt_q + AfW'(1);
            af_ph_d  = af_ph_q;
          end
        end
      end

      player_d          = raw[OutW-1:0];
      player_d[4]       = btn0;
      player_d[CoinBit] = ~clear_i & (coin_rise | (coin_cnt_q != '0));
    end

    always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        player_q    <= '0;
        coin_cnt_q  <= '0;
        coin_low_q  <= 1'b0;
        pause_low_q <= 1'b0;
        af_cnt_q    <= '0;
        af_ph_q     <= 1'b0;
        af_arm_q    <= 1'b0;
      end else begin
        player_q    <= player_d;
        coin_cnt_q  <= coin_cnt_d;
        coin_low_q  <= coin_low_d;
        pause_low_q <= pause_low_d;
        af_cnt_q    <= af_cnt_d;
        af_ph_q     <= af_ph_d;
        af_arm_q    <= af_arm_d;
      end
    end

    assign pause_rise[g]               = rise_l;
    assign player_o[OutW*g +: OutW]    = player_q;
  end

endmodule

// File: tb/tb_arcade_input.sv
// Scoreboard bench for arcade_input: stimulus queues expected outputs per cycle,
// a monitor pops and compares them just after each rising edge.
module tb_arcade_input;

  logic        clk;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [31:0] joy;
  logic [1:0]  af_en;
  logic        clear;
  logic [17:0] player;
  logic        pause;
  logic [1:0]  service;

  arcade_input #(
    .PLAYERS     (2),
    .BUTTONS     (3),
    .COIN_PULSE  (16),
    .AUTOFIRE_DIV(8)
  ) dut (
    .clk_sys_i    (clk),
    .reset_n_i    (reset_n),
    .ps2_key_i    (ps2_key),
    .joystick_i   (joy),
    .autofire_en_i(af_en),
    .clear_i      (clear),
    .player_o     (player),
    .pause_o      (pause),
    .service_o    (service)
  );

  typedef struct packed {
    int unsigned cyc;
    logic [17:0] pl;
    logic        pa;
    logic [1:0]  sv;
  } exp_t;

  exp_t        sb[$];
  string       sb_name[$];
  int unsigned cyc   = 0;
  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic expect_out(input int unsigned d, input logic [17:0] pl, input logic pa,
                            input logic [1:0] sv, input string name);
    exp_t e;
    int   idx;
    e.cyc = cyc + d;
    e.pl  = pl;
    e.pa  = pa;
    e.sv  = sv;
    idx   = sb.size();
    while (idx > 0 && sb[idx-1].cyc > e.cyc) idx--;
    sb.insert(idx, e);
    sb_name.insert(idx, name);
  endtask

  task automatic check_now(input string name, input logic [17:0] pl, input logic pa,
                           input logic [1:0] sv);
    n_chk++;
    if (player !== pl || pause !== pa || service !== sv) begin
      n_bad++;
      $display("FAIL %s: player=%h pause=%b service=%b, required player=%h pause=%b service=%b",
               name, player, pause, service, pl, pa, sv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2(input logic prs, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], prs, ext, code};
  endtask

  // Monitor
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e  = sb.pop_front();
        nm = sb_name.pop_front();
        n_chk++;
        if (e.cyc != cyc || player !== e.pl || pause !== e.pa || service !== e.sv) begin
          n_bad++;
          $display("FAIL %s cyc=%0d: player=%h pause=%b service=%b, required player=%h pause=%b service=%b",
                   nm, cyc, player, pause, service, e.pl, e.pa, e.sv);
        end
      end
    end
  end

  // Stimulus
  initial begin
    int unsigned guard;
    reset_n = 1'b1;
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h75};
    joy     = '0;
    af_en   = 2'b00;
    clear   = 1'b0;
    #1 reset_n = 1'b0;
    #1 check_now("reset_async", 18'h0, 1'b0, 2'b00);
    step(3);
    expect_out(1, 18'h0, 1'b0, 2'b00, "reset_hold");
    step(1);

    // Strobe already high at release -> one event on the first clock.
    reset_n = 1'b1;
    expect_out(1, 18'h0, 1'b0, 2'b00, "rel_lat1");
    expect_out(2, 18'h8, 1'b0, 2'b00, "rel_strobe_up");
    step(3);
    ps2(1'b0, 1'b0, 8'h75);
    expect_out(1, 18'h8, 1'b0, 2'b00, "up_rel_lat1");
    expect_out(2, 18'h0, 1'b0, 2'b00, "up_rel");
    step(3);
    ps2(1'b1, 1'b0, 8'h75);
    expect_out(1, 18'h0, 1'b0, 2'b00, "up_prs_lat1");
    expect_out(2, 18'h8, 1'b0, 2'b00, "up_prs");
    step(3);
    ps2(1'b0, 1'b0, 8'h75);
    expect_out(2, 18'h0, 1'b0, 2'b00, "up_rel2");
    step(3);
    ps2(1'b1, 1'b1, 8'h6b);
    expect_out(2, 18'h2, 1'b0, 2'b00, "left_ext");
    step(3);
    ps2(1'b0, 1'b1, 8'h6b);
    expect_out(2, 18'h0, 1'b0, 2'b00, "left_ext_rel");
    step(3);
    ps2(1'b1, 1'b0, 8'h99);
    expect_out(2, 18'h0, 1'b0, 2'b00, "unmapped");
    step(3);

    // Player 2 keys and service switches
    ps2(1'b1, 1'b0, 8'h1c);
    expect_out(2, 18'h2000, 1'b0, 2'b00, "p2_b0");
    step(3);
    ps2(1'b1, 1'b0, 8'h46);
    expect_out(2, 18'h2000, 1'b0, 2'b01, "svc0");
    step(3);
    ps2(1'b1, 1'b0, 8'h45);
    expect_out(2, 18'h2000, 1'b0, 2'b11, "svc1");
    step(3);
    ps2(1'b0, 1'b0, 8'h1c);
    expect_out(2, 18'h0, 1'b0, 2'b11, "p2_b0_rel");
    step(3);
    ps2(1'b0, 1'b0, 8'h46);
    expect_out(2, 18'h0, 1'b0, 2'b10, "svc0_rel");
    step(3);
    ps2(1'b0, 1'b0, 8'h45);
    expect_out(2, 18'h0, 1'b0, 2'b00, "svc1_rel");
    step(3);

    // Joystick passes with one cycle latency
    joy = 32'h0080_0008 | 32'h0001_0000;
    expect_out(1, 18'h10208, 1'b0, 2'b00, "joy_pass");
    step(2);
    joy = '0;
    expect_out(1, 18'h0, 1'b0, 2'b00, "joy_clr");
    step(2);

    // Coin held 100 cycles -> one 16-cycle pulse
    joy[8] = 1'b1;
    for (int d = 1; d <= 100; d++)
      expect_out(d, (d <= 16) ? 18'h100 : 18'h0, 1'b0, 2'b00, "coin_hold");
    step(100);
    joy[8] = 1'b0;
    expect_out(1, 18'h0, 1'b0, 2'b00, "coin_rel");
    step(3);
    // Re-press; a release/re-press inside the pulse is ignored
    joy[8] = 1'b1;
    for (int d = 1; d <= 30; d++)
      expect_out(d, (d <= 16) ? 18'h100 : 18'h0, 1'b0, 2'b00, "coin_again");
    step(3);
    joy[8] = 1'b0;
    step(2);
    joy[8] = 1'b1;
    step(27);
    joy[8] = 1'b0;
    step(2);

    // Reset mid coin pulse
    joy[8] = 1'b1;
    for (int d = 1; d <= 5; d++) expect_out(d, 18'h100, 1'b0, 2'b00, "coin_pre_rst");
    step(5);
    reset_n = 1'b0;
    #1 check_now("rst_mid_coin", 18'h0, 1'b0, 2'b00);
    expect_out(1, 18'h0, 1'b0, 2'b00, "rst_hold_coin");
    step(2);
    reset_n = 1'b1;
    for (int d = 1; d <= 10; d++) expect_out(d, 18'h0, 1'b0, 2'b00, "coin_held_no_pulse");
    step(10);
    joy[8] = 1'b0;
    expect_out(1, 18'h0, 1'b0, 2'b00, "coin_rel_post_rst");
    step(2);
    joy[8] = 1'b1;
    for (int d = 1; d <= 17; d++)
      expect_out(d, (d <= 16) ? 18'h100 : 18'h0, 1'b0, 2'b00, "coin_post_rst");
    step(20);
    joy[8] = 1'b0;
    step(2);

    // Pause: simultaneous edges toggle once, then keyboard toggles back
    joy[9]  = 1'b1;
    joy[25] = 1'b1;
    expect_out(1, 18'h0, 1'b1, 2'b00, "pause_dual");
    expect_out(2, 18'h0, 1'b1, 2'b00, "pause_dual_hold");
    step(3);
    joy = '0;
    expect_out(1, 18'h0, 1'b1, 2'b00, "pause_rel");
    step(2);
    ps2(1'b1, 1'b0, 8'h4d);
    expect_out(1, 18'h0, 1'b1, 2'b00, "pause_key_lat1");
    expect_out(2, 18'h0, 1'b0, 2'b00, "pause_key");
    step(3);
    ps2(1'b0, 1'b0, 8'h4d);
    expect_out(2, 18'h0, 1'b0, 2'b00, "pause_key_rel");
    step(3);

    // Autofire 8 high / 8 low on P1 button 0
    af_en  = 2'b01;
    joy[4] = 1'b1;
    for (int d = 1; d <= 40; d++)
      expect_out(d, (((d - 1) / 8) % 2 == 0) ? 18'h10 : 18'h0, 1'b0, 2'b00, "af_run");
    step(40);
    joy[4] = 1'b0;
    expect_out(1, 18'h0, 1'b0, 2'b00, "af_rel");
    expect_out(2, 18'h0, 1'b0, 2'b00, "af_rel2");
    step(3);
    joy[4] = 1'b1;
    for (int d = 1; d <= 12; d++)
      expect_out(d, (d <= 8) ? 18'h10 : 18'h0, 1'b0, 2'b00, "af_part");
    step(12);
    joy[4] = 1'b0;
    expect_out(1, 18'h0, 1'b0, 2'b00, "af_part_rel");
    step(2);
    joy[4] = 1'b1;
    for (int d = 1; d <= 10; d++)
      expect_out(d, (d <= 8) ? 18'h10 : 18'h0, 1'b0, 2'b00, "af_restart");
    step(10);
    joy[4] = 1'b0;
    expect_out(1, 18'h0, 1'b0, 2'b00, "af_restart_rel");
    step(2);
    af_en  = 2'b00;
    joy[4] = 1'b1;
    for (int d = 1; d <= 20; d++) expect_out(d, 18'h10, 1'b0, 2'b00, "af_off");
    step(20);
    joy[4] = 1'b0;
    expect_out(1, 18'h0, 1'b0, 2'b00, "af_off_rel");
    step(2);

    // Clear with a key latched and pause set
    joy[9] = 1'b1;
    expect_out(1, 18'h0, 1'b1, 2'b00, "pause_set");
    step(2);
    joy[9] = 1'b0;
    step(2);
    ps2(1'b1, 1'b0, 8'h14);
    joy[0] = 1'b1;
    expect_out(1, 18'h01, 1'b1, 2'b00, "pre_clr_lat1");
    expect_out(2, 18'h11, 1'b1, 2'b00, "pre_clr");
    step(3);
    clear = 1'b1;
    expect_out(1, 18'h01, 1'b0, 2'b00, "clear");
    step(1);
    clear = 1'b0;
    expect_out(1, 18'h01, 1'b0, 2'b00, "post_clr1");
    expect_out(2, 18'h01, 1'b0, 2'b00, "post_clr2");
    step(3);
    joy = '0;
    expect_out(1, 18'h0, 1'b0, 2'b00, "final_idle");
    step(2);

    guard = 0;
    while (sb.size() > 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      n_chk++;
      n_bad++;
      $display("FAIL drain: pending=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/arcade_input.md
ARCADE_INPUT -- requirements
Module: arcade_input

Interface
REQ-001 Parameter PLAYERS, default 2, number of player channels (1..4).
REQ-002 Parameter BUTTONS, default 3, fire buttons per player (1..8).
REQ-003 Parameter COIN_PULSE, default 16, coin output high time in clk_sys cycles (>=1).
REQ-004 Parameter AUTOFIRE_DIV, default 8, autofire half-period in clk_sys cycles (>=1).
REQ-005 clk_sys  in  1  single clock; all logic on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 ps2_key  in  11  hps_io key event: [10] toggle strobe, [9] pressed, [8] extended, [7:0] scancode.
REQ-008 joystick  in  16*PLAYERS  per-player hps_io word, player p at [16p+:16].
REQ-009 autofire_en  in  PLAYERS  per-player autofire enable for button 0.
REQ-010 clear  in  1  synchronous clear of key latches, coin and pause state (tied to download).
REQ-011 player  out  (6+BUTTONS)*PLAYERS  per-player controls, player p at [(6+BUTTONS)p+:(6+BUTTONS)].
REQ-012 pause  out  1  global pause level.
REQ-013 service  out  2  service switches {key 0, key 9}.

Function
REQ-014 Joystick word bit layout SHALL be: [0] right, [1] left, [2] down, [3] up, [4+:BUTTONS] buttons, [4+BUTTONS] start, [5+BUTTONS] coin, [6+BUTTONS] pause; bits above unused.
REQ-015 Player output layout SHALL equal joystick bits [5+BUTTONS:0] after keyboard merge, coin shaping and autofire.
REQ-016 Key event SHALL be taken when registered previous ps2_key[10] differs from current; latch for matched scancode set to ps2_key[9]; extended bit ignored; unmatched codes ignored.
REQ-017 Key map P1: 75 up, 72 down, 6B left, 74 right, 14/11/29 buttons 0/1/2, 16 start, 2E coin, 4D pause.
REQ-018 Key map P2: 2D up, 2B down, 23 left, 34 right, 1C/1B/15 buttons 0/1/2, 1E start, 36 coin; 46 service[0], 45 service[1].
REQ-019 Keys mapped to button index >= BUTTONS or player >= PLAYERS SHALL be ignored; players 3-4 joystick only.
REQ-020 Raw control per bit SHALL be key latch OR joystick bit.
REQ-021 Coin: rising edge of raw coin SHALL start a counter; output high exactly COIN_PULSE cycles; edges while counting ignored; new pulse only after raw coin seen low.
REQ-022 Pause: rising edge of raw pause on any player SHALL toggle pause state; simultaneous edges on several players in one cycle SHALL toggle once.
REQ-023 Autofire: when autofire_en[p] and raw button 0 held, output SHALL be high AUTOFIRE_DIV cycles, low AUTOFIRE_DIV cycles, repeating, starting high on the press cycle; release forces low and restarts phase; disabled passes raw level.
REQ-024 All outputs SHALL be registered; latency joystick change to output 1 cycle; ps2 strobe toggle to output 2 cycles; coin/pause first-high 1 cycle after raw edge.
REQ-025 clear SHALL zero all key latches, coin counters, pause state and autofire phase next edge; joystick inputs still pass while clear is high (coin/pause edge detection suppressed).
REQ-026 Counters SHALL be sized clog2 of parameter+1; no wrap while active.

Reset
REQ-027 reset_n low SHALL asynchronously zero all latches, counters, edge-detect registers and outputs (player=0, pause=0, service=0).
REQ-028 Previous-strobe register SHALL reset to 0, so a ps2_key[10]=1 present at deassertion produces one event on the first clock.
REQ-029 Reset mid coin pulse or autofire SHALL terminate it; no output resumes after release until a fresh raw edge.

Verification
REQ-030 PLAYERS=2,BUTTONS=3: ps2_key toggles with {pressed=1,code=75} -> player[3]=1 two cycles later; toggle with pressed=0 -> 0.
REQ-031 joystick[8] (P1 coin) held 100 cycles, COIN_PULSE=16 -> player[8] high exactly 16 cycles once; release, re-press -> second 16-cycle pulse.
REQ-032 joystick[9] and joystick[25] rise same cycle -> pause 0->1 once; P1 key 4D press -> pause 1->0.
REQ-033 autofire_en=01, AUTOFIRE_DIV=8, joystick[4] held 40 cycles -> player[4] pattern 8 high/8 low repeating, low on release; autofire_en=00 -> follows raw level.
REQ-034 clear pulsed with key 14 latched and pause=1 -> player[4]=0, pause=0 next cycle; joystick still passes.
REQ-035 reset_n asserted mid coin pulse -> all outputs 0 immediately; after release, coin still held -> no pulse until released and re-pressed.
